alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width.
REQ-002 SHALL have parameter: NREGS, 4, register-file depth (address width 2).
REQ-003 SHALL have port: Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: InstrValid  input  1  instruction offered.
REQ-006 SHALL have port: InstrReady  output  1  sequencer accepts instruction.
REQ-007 SHALL have port: Instr  input  16  [15:12] opcode, [11:10] rd, [9:8] rs1, [7:6] rs2, [7:0] imm (LDI only).
REQ-008 SHALL have port: ALUsel  output  4  operation select driven to external ALU.
REQ-009 SHALL have ports: OperandA, OperandB  output  DATA_W  operands to external ALU.
REQ-010 SHALL have port: ALUResult  input  DATA_W  combinational result from external ALU.
REQ-011 SHALL have port: Done  output  1  one-cycle pulse on instruction retirement.
REQ-012 SHALL have port: IllegalOp  output  1  one-cycle pulse, coincident with Done, for illegal opcode.
REQ-013 SHALL have ports: DbgAddr  input  2, DbgData  output  DATA_W  combinational register read.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE; no other states.
REQ-015 IDLE: InstrReady=1; on InstrValid&&InstrReady at edge T, SHALL latch Instr and enter EXEC.
REQ-016 InstrReady SHALL be 0 in EXEC and WB; Instr changes there are ignored.
REQ-017 EXEC (cycle T+1): OperandA=R[rs1], OperandB=R[rs2], ALUsel=opcode for legal ALU opcodes.
REQ-018 Legal ALU opcodes: 0001 add, 0010 sub, 0101 and, 0110 or, 0111 not, 1000 xor, 1001 shl1, 1011 pass.
REQ-019 Opcode 1111 (LDI) SHALL drive ALUsel=1011, OperandA=zero-extended imm[7:0], OperandB=0.
REQ-020 All other opcodes (0000, 0011, 0100, 1010, 1100-1110) are illegal: ALUsel=1011, no register write.
REQ-021 At end of EXEC, SHALL write ALUResult into R[rd] for legal and LDI opcodes.
REQ-022 WB (cycle T+2): Done=1; IllegalOp=1 only for illegal opcode; then IDLE.
REQ-023 Outside EXEC, ALUsel SHALL be 1011 and OperandA/OperandB 0; 0000 (ALU hold) never driven.
REQ-024 rd equal to rs1/rs2 SHALL use pre-write operand values; write visible on DbgData from WB onward.
REQ-025 Throughput: one instruction per 3 cycles; back-to-back InstrValid accepted at the next IDLE.
REQ-026 Arithmetic wraps modulo 2^DATA_W; no flags are generated.

Reset
REQ-027 Reset SHALL force IDLE, InstrReady=1, Done=0, IllegalOp=0, ALUsel=1011, operands 0, all R[i]=0.
REQ-028 Reset asserted in EXEC or WB SHALL abort the instruction: no write, no Done pulse.
REQ-029 First handshake after Reset release SHALL be accepted on the first rising edge with InstrValid=1.

Structure
REQ-030 Package alu_seq_pkg SHALL hold opcode constants, Instr field positions, state enum, and the idle ALUsel value 1011.
REQ-031 Register file SHALL be sub-module alu_seq_regfile: NREGS x DATA_W, two read ports plus debug read port, one write port, async reset.
REQ-032 Top level SHALL contain only the FSM, instruction latch, decode, and operand muxing.

Verification
REQ-033 Reset, then LDI R1 <- 0x05; LDI R2 <- 0x03; add R3=R1+R2 -> R3=0x00000008, Done at T+2 each.
REQ-034 LDI R0 <- 0x00; sub R1=R0-R2 (R2=3) -> R1=0xFFFFFFFD (wrap-around).
REQ-035 Opcode 0100 to rd=R1 -> IllegalOp and Done pulse together, R1 unchanged, ALUsel never 0100.
REQ-036 InstrValid held high for 3 instructions -> InstrReady low in EXEC/WB, accepts at every 3rd edge, 3 Done pulses.
REQ-037 Reset asserted during EXEC of add R3 -> no Done, R3=0, FSM in IDLE, InstrReady=1 next cycle.
REQ-038 xor R1=R1^R1 with R1=0xA5 -> R1=0; shl1 R2 with R2=0x80000001 -> R2=0x00000002.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, instruction field
// positions, FSM state type and opcode classification helpers.
package alu_seq_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned REG_W   = 2;
  localparam int unsigned IMM_W   = 8;

  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_LSB  = 10;
  localparam int unsigned RS1_LSB = 8;
  localparam int unsigned RS2_LSB = 6;
  localparam int unsigned IMM_LSB = 0;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_HOLD = 4'b0000;
  localparam opcode_t OP_ADD  = 4'b0001;
  localparam opcode_t OP_SUB  = 4'b0010;
  localparam opcode_t OP_AND  = 4'b0101;
  localparam opcode_t OP_OR   = 4'b0110;
  localparam opcode_t OP_NOT  = 4'b0111;
  localparam opcode_t OP_XOR  = 4'b1000;
  localparam opcode_t OP_SHL1 = 4'b1001;
  localparam opcode_t OP_PASS = 4'b1011;
  localparam opcode_t OP_LDI  = 4'b1111;

  // The external ALU is parked on "pass" whenever it is not executing.
  localparam opcode_t ALUSEL_IDLE = OP_PASS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB
  } state_t;

  function automatic logic is_alu_op(input opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_XOR, OP_SHL1, OP_PASS: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input opcode_t op);
    return is_alu_op(op) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file for the ALU sequencer: two operand read ports, one debug
// read port and a single write port, cleared by asynchronous reset.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [REG_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a  = regs_q[raddr_a];
  assign rdata_b  = regs_q[raddr_b];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Three-state instruction sequencer driving an external combinational ALU:
// latch instruction, present operands for one cycle, write back, pulse Done.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               InstrValid,
  output logic               InstrReady,
  input  logic [INSTR_W-1:0] Instr,
  output logic [OPC_W-1:0]   ALUsel,
  output logic [DATA_W-1:0]  OperandA,
  output logic [DATA_W-1:0]  OperandB,
  input  logic [DATA_W-1:0]  ALUResult,
  output logic               Done,
  output logic               IllegalOp,
  input  logic [REG_W-1:0]   DbgAddr,
  output logic [DATA_W-1:0]  DbgData
);

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               illegal_q, illegal_d;
  opcode_t            alusel_q, alusel_d;

  opcode_t            opc, opc_in;
  logic [REG_W-1:0]   rd, rs1, rs2;
  logic [IMM_W-1:0]   imm;
  logic               rf_we;
  logic [DATA_W-1:0]  rdata_a, rdata_b;
  logic [DATA_W-1:0]  opa, opb;

  assign opc    = instr_q[OPC_LSB +: OPC_W];
  assign rd     = instr_q[RD_LSB  +: REG_W];
  assign rs1    = instr_q[RS1_LSB +: REG_W];
  assign rs2    = instr_q[RS2_LSB +: REG_W];
  assign imm    = instr_q[IMM_LSB +: IMM_W];
  assign opc_in = Instr[OPC_LSB +: OPC_W];

  // The write lands at the end of EXEC, so operands read during EXEC are
  // always the pre-write values even when rd aliases rs1/rs2.
  assign rf_we = (state_q == ST_EXEC) && writes_rd(opc);

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    alusel_d  = alusel_q;
    case (state_q)
      ST_IDLE: begin
        if (InstrValid && ready_q) begin
          instr_d  = Instr;
          state_d  = ST_EXEC;
          ready_d  = 1'b0;
          alusel_d = is_alu_op(opc_in) ? opc_in : ALUSEL_IDLE;
        end
      end
      ST_EXEC: begin
        state_d   = ST_WB;
        done_d    = 1'b1;
        illegal_d = !writes_rd(opc);
        alusel_d  = ALUSEL_IDLE;
      end
      ST_WB: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d  = ST_IDLE;
        ready_d  = 1'b1;
        alusel_d = ALUSEL_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      alusel_q  <= ALUSEL_IDLE;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      alusel_q  <= alusel_d;
    end
  end

  always_comb begin
    opa = '0;
    opb = '0;
    if (state_q == ST_EXEC) begin
      if (opc == OP_LDI) begin
        opa[IMM_W-1:0] = imm;
      end else if (is_alu_op(opc)) begin
        opa = rdata_a;
        opb = rdata_b;
      end
    end
  end

  alu_seq_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk      (Clk),
    .rst      (Reset),
    .we       (rf_we),
    .waddr    (rd),
    .wdata    (ALUResult),
    .raddr_a  (rs1),
    .rdata_a  (rdata_a),
    .raddr_b  (rs2),
    .rdata_b  (rdata_b),
    .dbg_addr (DbgAddr),
    .dbg_data (DbgData)
  );

  assign InstrReady = ready_q;
  assign Done       = done_q;
  assign IllegalOp  = illegal_q;
  assign ALUsel     = alusel_q;
  assign OperandA   = opa;
  assign OperandB   = opb;

endmodule
